// File: rtl/bcd_to_binary.sv
// bcd_to_binary: converts a three-digit BCD number (000..999) to an 8-bit
// binary value using reverse double dabble. Values above 255 saturate to
// 8'hFF with overflow set. A digit above 9 aborts the request and reports
// error instead of a value.
module bcd_to_binary (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [3:0] Hundreds,
    input  logic [3:0] Tens,
    input  logic [3:0] Ones,
    output logic [7:0] binary,
    output logic       busy,
    output logic       done,
    output logic       overflow,
    output logic       error
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        FINISH = 2'b10
    } state_t;

    // Working register layout: {hundreds, tens, ones, bin[7:0]}
    localparam int WORK_W  = 20;
    localparam int BIN_W   = 8;
    localparam int LAST_IT = 7;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [WORK_W-1:0] work_q, work_d;
    logic              err_pend_q, err_pend_d;
    logic [BIN_W-1:0]  binary_q, binary_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic              error_q, error_d;

    logic              digits_ok;
    logic [WORK_W-1:0] work_step;

    // A BCD nibble that reads 8 or more after the right shift held a
    // weight-10 carry in its upper bit; subtracting 3 restores the digit
    // (16/2 = 8 in binary vs 10/2 = 5 in decimal).
    function automatic logic [3:0] adjust_nibble(input logic [3:0] n);
        logic [3:0] r;
        r = n;
        if (n >= 4'd8) begin
            r = n - 4'd3;
        end
        return r;
    endfunction

    // One reverse double dabble iteration: shift right, then correct
    // each of the three BCD nibbles in parallel.
    function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
        logic [WORK_W-1:0] s;
        s = {1'b0, w[WORK_W-1:1]};
        s[19:16] = adjust_nibble(s[19:16]);
        s[15:12] = adjust_nibble(s[15:12]);
        s[11:8]  = adjust_nibble(s[11:8]);
        return s;
    endfunction

    // Digit range check on the request inputs
    always_comb begin
        digits_ok = (Hundreds <= 4'd9) && (Tens <= 4'd9) && (Ones <= 4'd9);
        work_step = dabble_step(work_q);
    end

    // Next-state and output logic; done defaults low so it pulses once
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        err_pend_d = err_pend_q;
        binary_d   = binary_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        error_d    = error_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    busy_d = 1'b1;
                    if (digits_ok) begin
                        work_d     = {Hundreds, Tens, Ones, 8'h00};
                        cnt_d      = 3'd0;
                        err_pend_d = 1'b0;
                        state_d    = SHIFT;
                    end else begin
                        err_pend_d = 1'b1;
                        state_d    = FINISH;
                    end
                end
            end

            SHIFT: begin
                work_d = work_step;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'(LAST_IT)) begin
                    state_d = FINISH;
                end
            end

            FINISH: begin
                if (err_pend_q) begin
                    binary_d   = '0;
                    overflow_d = 1'b0;
                    error_d    = 1'b1;
                end else if (work_q[WORK_W-1:BIN_W] != '0) begin
                    binary_d   = 8'hFF;
                    overflow_d = 1'b1;
                    error_d    = 1'b0;
                end else begin
                    binary_d   = work_q[BIN_W-1:0];
                    overflow_d = 1'b0;
                    error_d    = 1'b0;
                end
                err_pend_d = 1'b0;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous clear
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            work_q     <= '0;
            err_pend_q <= 1'b0;
            binary_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            err_pend_q <= err_pend_d;
            binary_q   <= binary_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
        end
    end

    assign binary   = binary_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign error    = error_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Testbench for bcd_to_binary: directed sequences plus an exhaustive sweep
// of all valid digit triples, with a result scoreboard and timing checks.
module tb_bcd_to_binary;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [3:0] Hundreds;
    logic [3:0] Tens;
    logic [3:0] Ones;
    logic [7:0] binary;
    logic       busy;
    logic       done;
    logic       overflow;
    logic       error;

    typedef struct {
        logic [7:0] bin;
        logic       ov;
        logic       err;
    } exp_t;

    exp_t       sb[$];
    int         errors;
    int         checks;
    logic [7:0] held_bin;
    logic       held_ov;
    logic       held_err;

    bcd_to_binary dut (
        .clock   (clock),
        .resetn  (resetn),
        .start   (start),
        .Hundreds(Hundreds),
        .Tens    (Tens),
        .Ones    (Ones),
        .binary  (binary),
        .busy    (busy),
        .done    (done),
        .overflow(overflow),
        .error   (error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start with the given digits; caller is just past a
    // negedge. Digits are scrambled right after the sampling edge.
    task automatic issue(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                         input bit push);
        exp_t e;
        int   v;
        v = 100 * int'(h) + 10 * int'(t) + int'(o);
        if (h > 4'd9 || t > 4'd9 || o > 4'd9) begin
            e.bin = 8'd0; e.ov = 1'b0; e.err = 1'b1;
        end else begin
            e.bin = (v > 255) ? 8'hFF : 8'(v);
            e.ov  = (v > 255);
            e.err = 1'b0;
        end
        if (push) sb.push_back(e);
        Hundreds = h;
        Tens     = t;
        Ones     = o;
        start    = 1'b1;
        @(posedge clock);
        #1;
        start    = 1'b0;
        Hundreds = 4'($urandom_range(15, 0));
        Tens     = 4'($urandom_range(15, 0));
        Ones     = 4'($urandom_range(15, 0));
    endtask

    // Wait for done, checking latency, busy length and held outputs; the
    // optional pulse_at injects a 9,9,9 start while busy. Returns at the
    // negedge where done is observed.
    task automatic wait_done(input int exp_cyc, input int exp_busy, input int pulse_at);
        int   cyc;
        int   bcnt;
        bit   got;
        exp_t e;
        cyc  = 0;
        bcnt = 0;
        got  = 0;
        while (!got && cyc < 20) begin
            @(negedge clock);
            cyc++;
            start = (cyc == pulse_at);
            if (cyc == pulse_at) begin
                Hundreds = 4'd9; Tens = 4'd9; Ones = 4'd9;
            end
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                got = 1;
            end else begin
                chk("held_binary", binary, held_bin);
                chk("held_overflow", overflow, held_ov);
                chk("held_error", error, held_err);
            end
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        chk("done_latency", cyc, exp_cyc);
        chk("busy_cycles", bcnt, exp_busy);
        chk("sb_nonempty", (sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("binary", binary, e.bin);
            chk("overflow", overflow, e.ov);
            chk("error", error, e.err);
            held_bin = e.bin;
            held_ov  = e.ov;
            held_err = e.err;
        end
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        held_bin = 8'd0;
        held_ov  = 1'b0;
        held_err = 1'b0;
        resetn   = 1'b0;
        start    = 1'b0;
        Hundreds = 4'd0;
        Tens     = 4'd0;
        Ones     = 4'd0;

        // Reset state
        repeat (3) @(negedge clock);
        chk("rst_binary", binary, 8'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_error", error, 1'b0);
        resetn = 1'b1;

        // First start right after release, basic value
        issue(4'd1, 4'd2, 4'd3, 1'b1);
        wait_done(10, 9, 0);
        @(negedge clock);
        chk("done_single_cycle", done, 1'b0);

        // Saturation boundaries
        issue(4'd2, 4'd5, 4'd5, 1'b1); wait_done(10, 9, 0); @(negedge clock);
        issue(4'd2, 4'd5, 4'd6, 1'b1); wait_done(10, 9, 0); @(negedge clock);
        issue(4'd9, 4'd9, 4'd9, 1'b1); wait_done(10, 9, 0); @(negedge clock);
        issue(4'd0, 4'd0, 4'd0, 1'b1); wait_done(10, 9, 0); @(negedge clock);

        // Invalid digit, then a valid request
        issue(4'd0, 4'hA, 4'd0, 1'b1); wait_done(2, 1, 0); @(negedge clock);
        issue(4'd0, 4'd4, 4'd2, 1'b1); wait_done(10, 9, 0); @(negedge clock);

        // Start while busy is ignored; start in done cycle is accepted
        issue(4'd1, 4'd0, 4'd0, 1'b1);
        wait_done(10, 9, 4);
        issue(4'd0, 4'd7, 4'd7, 1'b1);
        wait_done(10, 9, 0);
        @(negedge clock);

        // Reset mid-conversion aborts with no done pulse
        issue(4'd2, 4'd0, 4'd0, 1'b1);
        repeat (4) begin
            @(negedge clock);
            chk("pre_abort_done", done, 1'b0);
        end
        resetn = 1'b0;
        #1;
        chk("abort_binary", binary, 8'd0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_overflow", overflow, 1'b0);
        chk("abort_error", error, 1'b0);
        void'(sb.pop_back());
        held_bin = 8'd0;
        held_ov  = 1'b0;
        held_err = 1'b0;
        repeat (2) begin
            @(negedge clock);
            chk("rst_no_done", done, 1'b0);
        end
        resetn = 1'b1;
        issue(4'd0, 4'd1, 4'd9, 1'b1);
        wait_done(10, 9, 0);

        // Exhaustive sweep of valid digit triples
        for (int h = 0; h < 10; h++) begin
            for (int t = 0; t < 10; t++) begin
                for (int o = 0; o < 10; o++) begin
                    @(negedge clock);
                    chk("idle_done_low", done, 1'b0);
                    issue(4'(h), 4'(t), 4'(o), 1'b1);
                    wait_done(10, 9, 0);
                end
            end
        end

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary.md
BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; all other state SHALL be rising-edge registered.
REQ-002 clock  input  1  system clock, rising edge.
REQ-003 resetn  input  1  asynchronous active-low reset.
REQ-004 start  input  1  conversion request, sampled only in IDLE.
REQ-005 Hundreds  input  4  BCD hundreds digit, sampled with start.
REQ-006 Tens  input  4  BCD tens digit, sampled with start.
REQ-007 Ones  input  4  BCD ones digit, sampled with start.
REQ-008 binary  output  8  converted value, held until the next done.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 done  output  1  one-cycle pulse when binary, overflow and error are valid.
REQ-011 overflow  output  1  value above 255; valid with done, held until the next done.
REQ-012 error  output  1  a sampled digit was above 9; valid with done, held until the next done.

Function
REQ-013 Algorithm: reverse double dabble on a 20-bit working register {bcd[11:0], bin[7:0]}.
REQ-014 One iteration per SHIFT cycle:
- Shift the whole register right by one, MSB filled with 0.
- Then, for each BCD nibble that is 8 or more, subtract 3 from it.
- All three nibbles are adjusted in the same cycle.
REQ-015 The FSM states SHALL be IDLE, SHIFT and FINISH, encoded in 2 bits; the unused code SHALL go to IDLE.
REQ-016 IDLE with start=1 and all digits 9 or below, at edge E0:
- Load bcd = {Hundreds, Tens, Ones} and bin = 0.
- Set the iteration counter to 0 and busy=1.
- Go to SHIFT.
REQ-017 IDLE with start=1 and any digit above 9, at edge E0:
- Set the error-pending flag and busy=1.
- Go to FINISH without iterating.
REQ-018 SHIFT SHALL perform exactly 8 iterations, at edges E1..E8 (3-bit counter); after the 8th it SHALL go to FINISH.
REQ-019 FINISH, at the next edge:
- If error is pending: binary=0, overflow=0, error=1.
- Else if bcd is nonzero: binary=8'hFF (saturate), overflow=1, error=0.
- Else: binary=bin, overflow=0, error=0.
- In all cases: done=1, busy=0, go to IDLE.
REQ-020 Latency for a valid conversion: done SHALL be high for the single cycle following E9, and busy SHALL be high for the 9 cycles following E0..E8.
REQ-021 Latency for an invalid digit: done SHALL be high for the cycle following E1, and busy SHALL be high for one cycle.
REQ-022 done SHALL be deasserted at every edge except the FINISH-to-IDLE edge.
REQ-023 start while busy=1 SHALL be ignored; it SHALL NOT be queued, restart the conversion or alter the latched digits.
REQ-024 start=1 in the cycle where done=1 (FSM already in IDLE) SHALL be accepted as a new conversion, giving back-to-back operation every 10 cycles.
REQ-025 Input digit changes after E0 SHALL NOT affect the result.
REQ-026 binary, overflow and error SHALL change only on a done edge or on reset.

Reset
REQ-027 On resetn=0, asynchronously:
- State=IDLE, counter=0, working register=0, error-pending=0.
- binary=0, busy=0, done=0, overflow=0, error=0.
REQ-028 Reset asserted mid-conversion SHALL abort it with no done pulse.
REQ-029 After resetn rises, the first start SHALL be accepted on the first rising edge where it is high.

Verification
REQ-030 Digits 1,2,3 with a one-cycle start -> binary=8'd123, overflow=0, error=0; done exactly 9 cycles after the start edge; busy high for 9 cycles.
REQ-031 Digits 2,5,5 -> binary=255, overflow=0. Digits 2,5,6 -> binary=255, overflow=1. Digits 9,9,9 -> binary=255, overflow=1. Digits 0,0,0 -> binary=0, overflow=0.
REQ-032 Digits 0,4'hA,0 with start -> done one cycle after the start edge with error=1, binary=0, busy high for one cycle; a following 0,4,2 request -> binary=42, error=0.
REQ-033 Start 1,0,0; pulse start with digits 9,9,9 at cycle 4 -> second start ignored, result 100. Start 0,7,7 in the done cycle -> accepted, result 77 after 9 more cycles.
REQ-034 Start 2,0,0; assert resetn=0 at cycle 5 -> all outputs 0 immediately and no done pulse. After release, start 0,1,9 -> binary=19.
REQ-035 Exhaustive self-check: all 1000 valid digit triples, compared against value min(100H+10T+O, 255) and overflow (value>255), with done timing checked on each.
